// File: rtl/adder_result_accumulator.sv
// Sums NUM_SAMPLES 5-bit adder results ({carry,sum}) per frame into an ACC_W-bit total with a sticky overflow flag; ACC_SATURATE_EN clamps instead of wrapping.
// Latency: out_valid rises on the edge that accepts the frame's last sample; the total is registered and valid in that cycle.
// Backpressure: in_ready/out_valid come only from the state register; HOLD persists with a stable total until out_ready.
module adder_result_accumulator #(
    parameter int ACC_W       = 8,
    parameter int NUM_SAMPLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_sum,
    input  logic             in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_overflow
);

    localparam int CNT_W = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;

    localparam logic [0:0] ST_ACCUM = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;

    logic [0:0]       state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;

    logic [ACC_W:0]   sample_ext;
    logic [ACC_W:0]   sum_ext;
    logic [ACC_W-1:0] acc_next;
    logic             last;

    assign sample_ext = {{(ACC_W-4){1'b0}}, in_carry, in_sum};
    assign sum_ext    = {1'b0, acc} + sample_ext;
    assign last       = (cnt == CNT_W'(NUM_SAMPLES - 1));

    always_comb begin
        acc_next = sum_ext[ACC_W-1:0];
`ifdef ACC_SATURATE_EN
        // Once clamped, any further non-zero sample overflows again and stays clamped.
        if (sum_ext[ACC_W]) begin
            acc_next = '1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_ACCUM;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else if (clear) begin
            state <= ST_ACCUM;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                ST_ACCUM: begin
                    if (in_valid) begin
                        acc <= acc_next;
                        ovf <= ovf | sum_ext[ACC_W];
                        cnt <= cnt + CNT_W'(1);
                        if (last) begin
                            state <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state <= ST_ACCUM;
                        acc   <= '0;
                        cnt   <= '0;
                        ovf   <= 1'b0;
                    end
                end
                default: state <= ST_ACCUM;
            endcase
        end
    end

    assign in_ready     = (state == ST_ACCUM);
    assign out_valid    = (state == ST_HOLD);
    assign out_acc      = acc;
    assign out_overflow = ovf;

endmodule

// File: tb/tb_adder_result_accumulator.sv
// Bench for adder_result_accumulator: an 8-bit instance (a_*) and a 6-bit instance (b_*) for overflow,
// frame totals checked through per-instance scoreboards plus direct handshake checks.
module tb_adder_result_accumulator;

    logic clk;
    logic rst;

    logic       a_clear, a_in_valid, a_in_ready, a_in_carry, a_out_valid, a_out_ready, a_out_overflow;
    logic [3:0] a_in_sum;
    logic [7:0] a_out_acc;

    logic       b_clear, b_in_valid, b_in_ready, b_in_carry, b_out_valid, b_out_ready, b_out_overflow;
    logic [3:0] b_in_sum;
    logic [5:0] b_out_acc;

    adder_result_accumulator #(.ACC_W(8), .NUM_SAMPLES(4)) dut_a (
        .clk(clk), .rst(rst), .clear(a_clear),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_sum(a_in_sum), .in_carry(a_in_carry),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_acc(a_out_acc), .out_overflow(a_out_overflow)
    );

    adder_result_accumulator #(.ACC_W(6), .NUM_SAMPLES(4)) dut_b (
        .clk(clk), .rst(rst), .clear(b_clear),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_sum(b_in_sum), .in_carry(b_in_carry),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_acc(b_out_acc), .out_overflow(b_out_overflow)
    );

    typedef struct packed {
        logic [7:0] acc;
        logic       ovf;
    } res_t;

    typedef struct {
        logic       sel;
        logic [4:0] s [4];
        int         exp_acc;
        logic       exp_ovf;
    } vec_t;

    res_t q_a[$];
    res_t q_b[$];
    int   errors = 0;
    int   checks = 0;
    int   xfer_a = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic sel, input int s0, input int s1, input int s2, input int s3,
                                input int acc, input logic ovf);
        vec_t v;
        v.sel = sel;
        v.s[0] = 5'(s0); v.s[1] = 5'(s1); v.s[2] = 5'(s2); v.s[3] = 5'(s3);
        v.exp_acc = acc;
        v.exp_ovf = ovf;
        return v;
    endfunction

    function automatic logic ov(input logic sel);
        return sel ? b_out_valid : a_out_valid;
    endfunction

    function automatic logic ir(input logic sel);
        return sel ? b_in_ready : a_in_ready;
    endfunction

    // Scoreboard: compare each completed frame when it is handed to the consumer.
    always @(negedge clk) begin
        if (a_in_valid && a_in_ready) xfer_a++;
        if (a_out_valid && a_out_ready) begin
            if (q_a.size() == 0) chk("a_unexpected_frame", 1, 0);
            else begin
                res_t r;
                r = q_a.pop_front();
                chk("a_out_acc", int'(a_out_acc), int'(r.acc));
                chk("a_out_overflow", int'(a_out_overflow), int'(r.ovf));
            end
        end
        if (b_out_valid && b_out_ready) begin
            if (q_b.size() == 0) chk("b_unexpected_frame", 1, 0);
            else begin
                res_t r;
                r = q_b.pop_front();
                chk("b_out_acc", int'(b_out_acc), int'(r.acc));
                chk("b_out_overflow", int'(b_out_overflow), int'(r.ovf));
            end
        end
    end

    task automatic put(input logic sel, input logic [4:0] s);
        if (sel) begin
            b_in_valid = 1'b1; b_in_carry = s[4]; b_in_sum = s[3:0];
        end else begin
            a_in_valid = 1'b1; a_in_carry = s[4]; a_in_sum = s[3:0];
        end
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
    endtask

    task automatic push(input logic sel, input int acc, input logic ovf);
        res_t r;
        r.acc = 8'(acc);
        r.ovf = ovf;
        if (sel) q_b.push_back(r);
        else     q_a.push_back(r);
    endtask

    // Drives one four-sample frame with the consumer ready; the frame drains on the following edge.
    task automatic run_frame(input vec_t v);
        push(v.sel, v.exp_acc, v.exp_ovf);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) chk("out_valid_before_last", int'(ov(v.sel)), 0);
            put(v.sel, v.s[i]);
        end
        chk("out_valid_after_last", int'(ov(v.sel)), 1);
        chk("in_ready_in_hold", int'(ir(v.sel)), 0);
        @(posedge clk); #1;
        chk("in_ready_after_drain", int'(ir(v.sel)), 1);
    endtask

    vec_t tbl [10];

    initial begin
        tbl[0] = mk(0, 9, 16, 31, 5, 61, 0);
        tbl[1] = mk(0, 0, 0, 0, 0, 0, 0);
        tbl[2] = mk(0, 31, 31, 31, 31, 124, 0);
        tbl[3] = mk(0, 1, 2, 4, 8, 15, 0);
        tbl[4] = mk(0, 16, 16, 16, 16, 64, 0);
        tbl[5] = mk(1, 31, 31, 1, 0, 63, 0);
        tbl[6] = mk(1, 10, 10, 10, 10, 40, 0);
`ifdef ACC_SATURATE_EN
        tbl[7] = mk(1, 31, 31, 31, 1, 63, 1);
        tbl[8] = mk(1, 31, 31, 2, 0, 63, 1);
        tbl[9] = mk(1, 31, 31, 31, 31, 63, 1);
`else
        tbl[7] = mk(1, 31, 31, 31, 1, 30, 1);
        tbl[8] = mk(1, 31, 31, 2, 0, 0, 1);
        tbl[9] = mk(1, 31, 31, 31, 31, 60, 1);
`endif

        rst = 1'b1;
        a_clear = 0; a_in_valid = 0; a_in_sum = 0; a_in_carry = 0; a_out_ready = 1;
        b_clear = 0; b_in_valid = 0; b_in_sum = 0; b_in_carry = 0; b_out_ready = 1;
        #12;
        chk("rst_in_ready", int'(a_in_ready), 1);
        chk("rst_out_valid", int'(a_out_valid), 0);
        chk("rst_out_acc", int'(a_out_acc), 0);
        chk("rst_out_overflow", int'(a_out_overflow), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) run_frame(tbl[i]);
        // A fresh frame after an overflowing one must start with the flag clear.
        run_frame(tbl[6]);

        // Back-pressure: HOLD persists, new sample waits until the cycle after out_ready.
        a_out_ready = 1'b0;
        push(0, 10, 0);
        put(0, 1); put(0, 2); put(0, 3); put(0, 4);
        a_in_valid = 1'b1; a_in_sum = 4'd5; a_in_carry = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("bp_in_ready", int'(a_in_ready), 0);
            chk("bp_out_acc", int'(a_out_acc), 10);
        end
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_exit_out_valid", int'(a_out_valid), 0);
        chk("bp_exit_in_ready", int'(a_in_ready), 1);
        push(0, 20, 0);
        @(posedge clk); #1;
        put(0, 5); put(0, 5); put(0, 5);
        chk("bp_next_hold", int'(a_out_valid), 1);
        @(posedge clk); #1;

        // Gaps in in_valid: only the four offered cycles transfer.
        begin
            logic [6:0] pat;
            int x0;
            pat = 7'b1011001;
            x0 = xfer_a;
            push(0, 8, 0);
            for (int i = 0; i < 7; i++) begin
                if (i == 6) chk("gap_out_valid_before", int'(a_out_valid), 0);
                a_in_valid = pat[i]; a_in_sum = 4'd2; a_in_carry = 1'b0;
                @(posedge clk); #1;
            end
            a_in_valid = 1'b0;
            chk("gap_out_valid", int'(a_out_valid), 1);
            chk("gap_transfers", xfer_a - x0, 4);
            @(posedge clk); #1;
        end

        // Clear mid-frame drops both the partial total and the coincident sample.
        put(0, 7); put(0, 7);
        a_clear = 1'b1; a_in_valid = 1'b1; a_in_sum = 4'd7; a_in_carry = 1'b0;
        @(posedge clk); #1;
        a_clear = 1'b0; a_in_valid = 1'b0;
        run_frame(mk(0, 1, 1, 1, 1, 4, 0));

        // Clear in HOLD discards the frame.
        a_out_ready = 1'b0;
        put(0, 3); put(0, 3); put(0, 3); put(0, 3);
        a_clear = 1'b1;
        @(posedge clk); #1;
        a_clear = 1'b0;
        chk("clear_hold_out_valid", int'(a_out_valid), 0);
        chk("clear_hold_out_acc", int'(a_out_acc), 0);
        a_out_ready = 1'b1;
        run_frame(tbl[3]);

        // Asynchronous reset while holding a frame.
        a_out_ready = 1'b0;
        put(0, 9); put(0, 16); put(0, 31); put(0, 5);
        chk("pre_rst_out_valid", int'(a_out_valid), 1);
        #3 rst = 1'b1;
        #1;
        chk("arst_out_valid", int'(a_out_valid), 0);
        chk("arst_out_acc", int'(a_out_acc), 0);
        chk("arst_in_ready", int'(a_in_ready), 1);
        chk("arst_out_overflow", int'(a_out_overflow), 0);
        #2 rst = 1'b0;
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        run_frame(tbl[0]);

        repeat (3) @(posedge clk);
        #1;
        chk("a_queue_drained", q_a.size(), 0);
        chk("b_queue_drained", q_b.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule

// File: doc/adder_result_accumulator.md
# adder_result_accumulator

Downstream stage of the 4-bit ripple-carry adder. Each cycle it can take one adder result, the 4-bit sum plus its carry, treated as a 5-bit value. It accumulates a fixed number of results into a wider register and presents the frame total on a valid/ready output. It sits between the combinational adder and any consumer that needs a registered, flow-controlled running total.

## Interface
- ACC_W, default 8: accumulator/output width, ≥ 5.
- NUM_SAMPLES, default 4: results per frame, ≥ 1.
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous frame abort; discards the partial total.
- in_valid  input  1  in_sum/in_carry hold a valid adder result.
- in_ready  output  1  block can accept a result this cycle.
- in_sum  input  4  adder sum bits.
- in_carry  input  1  adder carry_out.
- out_valid  output  1  out_acc/out_overflow hold a completed frame.
- out_ready  input  1  consumer accepts the frame.
- out_acc  output  ACC_W  frame total.
- out_overflow  output  1  total exceeded 2^ACC_W − 1 during the frame.

One clock; reset is asynchronous and active-high.

## Operation
- Sample value: {in_carry, in_sum}, range 0..31, zero-extended to ACC_W+1 bits.
- Input transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
- FSM has two states; the state is a register:
  - ACCUM: in_ready=1, out_valid=0. Each transfer does acc ← acc + sample and cnt ← cnt + 1. A transfer with cnt == NUM_SAMPLES−1 moves to HOLD.
  - HOLD: in_ready=0, out_valid=1. acc, cnt and ovf are frozen. An output transfer sets acc, cnt and ovf to 0 and returns to ACCUM.
- Overflow: ovf is sticky within a frame. It is set when bit ACC_W of the (ACC_W+1)-bit sum is 1.
- out_acc = acc register. out_overflow = ovf register. Both are meaningful only while out_valid=1.
- cnt width is clog2(NUM_SAMPLES), minimum 1 bit. For NUM_SAMPLES=1, every transfer goes straight to HOLD.
- Priority: rst > clear > transfer.
  - clear in any state sets acc=0, cnt=0, ovf=0 and the state to ACCUM.
  - A result offered in the same cycle as clear is dropped.
  - A HOLD frame cleared before out_ready is lost.
- in_valid while in HOLD: ignored. The upstream must hold its data until in_ready=1.
- Reset values: state=ACCUM, acc=0, cnt=0, ovf=0, in_ready=1, out_valid=0, out_acc=0, out_overflow=0.
- Reset mid-frame: everything returns to these values immediately, without waiting for a clock edge.

## Timing
- in_ready and out_valid are decoded from the state register only. There is no combinational path from in_valid or out_ready.
- Latency: out_valid rises on the edge that accepts the last sample of the frame. out_acc is valid in the same cycle.
- Throughput: 1 sample/cycle in ACCUM. Each frame takes at least NUM_SAMPLES + 1 cycles because HOLD lasts at least one cycle.
- A sample offered in the same cycle HOLD exits is not accepted. in_ready rises the following cycle.
- Back-pressure: while out_ready=0, HOLD persists indefinitely with out_acc stable.

## Configuration
- ACC_SATURATE_EN defined: on overflow, acc clamps to 2^ACC_W − 1 and ovf is set. Later samples in the same frame leave acc at the maximum.
- ACC_SATURATE_EN undefined: acc wraps modulo 2^ACC_W, and ovf is still set.
- No other behaviour differs between the two builds.

## Test plan
- Basic frame (ACC_W=8, N=4): samples (9,c0), (0,c1), (15,c1), (5,c0), one per cycle. Expected: out_valid=1 on the 4th accepting edge, out_acc=61 (0x3D), out_overflow=0.
- Overflow (ACC_W=6, N=4): samples 31, 31, 31, 1. Expected:
  - without macro: out_acc=30, out_overflow=1.
  - with ACC_SATURATE_EN: out_acc=63, out_overflow=1.
- Back-pressure: complete a frame, hold out_ready=0 for 3 cycles with in_valid=1 and a new sample. Expected: in_ready=0, out_acc stable, and no sample accepted until the cycle after out_ready=1. The next frame then starts from 0.
- Gaps: N=4, in_valid toggled 1,0,0,1,1,0,1 with samples of 2. Expected: exactly 4 transfers and out_acc=8.
- Clear: after 2 samples of 7, pulse clear with in_valid=1 and a sample of 7, then send 4 samples of 1. Expected: the sample in the clear cycle is dropped and the frame gives out_acc=4, out_overflow=0.
- Reset mid-HOLD: assert rst asynchronously between clock edges. Expected: out_valid=0, out_acc=0 and in_ready=1 before the next edge. The first frame after release matches the basic scenario.
